control_pipe: RTL and testbench
===============================

// Module: control_pipe
// PURPOSE
//  Carries decoder control lines from ID through ID/EX, EX/MEM and MEM/WB so each stage sees its
//  own instruction's controls. Inserts bubbles for branch flush and load-use stall, freezes on hold.
//  Sits directly downstream of the opcode decoder; feeds ALU control, data memory and writeback.
// PARAMETERS
//  REG_W   5    register-index width
//  ZERO_REG 31  index of XZR; never a hazard source/destination
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      async active-low reset
//  id_valid      in   1      ID holds a real instruction
//  id_aluOp      in   2      decoder aluOp
//  id_aluSrc     in   1      decoder aluSrc
//  id_branch     in   1      decoder branch
//  id_isZeroBranch in 1      decoder CBZ flag
//  id_isUnconBranch in 1     decoder B flag
//  id_memRead    in   1      decoder memRead
//  id_memWrite   in   1      decoder memWrite
//  id_regWrite   in   1      decoder regWrite
//  id_mem2reg    in   1      decoder mem2reg (X allowed when regWrite=0)
//  id_rd         in   REG_W  destination index
//  id_rs1/id_rs2 in   REG_W  source indices (rs2 already reg2loc-selected)
//  id_rs1_used/id_rs2_used in 1  source actually read
//  hold          in   1      freeze all stages (e.g. memory wait)
//  flush         in   1      branch taken in MEM; kill ID and EX instructions
//  stall_out     out  1      load-use stall: PC and IF/ID must hold
//  ex_valid,ex_aluOp[1:0],ex_aluSrc                     out  EX-stage controls
//  mem_valid,mem_branch,mem_isZeroBranch,mem_isUnconBranch,mem_memRead,mem_memWrite out MEM controls
//  wb_valid,wb_regWrite,wb_mem2reg                       out  WB controls
//  ex_rd,mem_rd,wb_rd    out REG_W  destination per stage
// BEHAVIOUR
//  - Reset (async, rst_n=0): every output and stage register 0, incl. rd fields; stall_out=0.
//  - Latency: ID->EX 1 cycle, ->MEM 2, ->WB 3. Outputs are registered; stall_out is combinational.
//  - Bubble = valid=0 with all control bits 0 (rd=0). A stage whose valid=0 drives all controls 0.
//  - id_valid=0 loads a bubble into ID/EX. X on id_mem2reg is registered as 0 when id_regWrite=0.
//  - Per-edge priority: flush > hold > load-use bubble > normal advance.
//    flush: ID/EX<=bubble, EX/MEM<=bubble, MEM/WB<=EX/MEM content (advances); stall_out forced 0.
//    hold (no flush): all three stage registers keep value; stall_out still computed.
//    load-use (stall_out=1): ID/EX<=bubble; EX/MEM, MEM/WB advance normally.
//    normal: ID->ID/EX->EX/MEM->MEM/WB shift.
//  - Load-use: stall_out=1 when id_valid & ex_valid & ex_memRead & ex_rd!=ZERO_REG &
//    ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). Stalls exactly 1 cycle
//    because the bubble clears ex_memRead.
//  - flush and load-use simultaneous: flush wins, no stall (ID instruction is dead).
//  - Reset mid-operation: all in-flight instructions discarded; no partial write or mem access.
//  - Back-to-back flushes each re-bubble ID/EX and EX/MEM; no underflow or counter state.
// CONFIGURATION
//  HAZARD_DETECT_EN defined: load-use detection above implemented.
//  HAZARD_DETECT_EN undefined: stall_out tied 0, no bubble inserted; software must schedule a
//  slot after each LDUR. id_rs1/id_rs2/_used then unused. All other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 mid-stream with ADD in all stages -> all outputs 0 same cycle, stay 0 until id_valid.
//  2 ADD (aluOp=10,regWrite=1,rd=3) -> ex_aluOp=10 at +1, mem_* 0 at +2, wb_regWrite=1,wb_rd=3 at +3.
//  3 LDUR rd=5 then ADD rs1=5 -> stall_out=1 one cycle, ex_valid=0 next, ADD reaches EX one cycle later.
//  4 LDUR rd=31 then ADD rs1=31 -> stall_out=0 (ZERO_REG); also rs2_used=0 with rs2=ex_rd -> no stall.
//  5 CBZ in MEM with flush=1 and hold=1 -> ex_valid=0, mem_valid=0, wb_* gets CBZ (regWrite=0).
//  6 hold=1 for 3 cycles with STUR in EX -> all outputs unchanged; after release mem_memWrite=1 once.

Source files
------------

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_pipe
// Purpose  : Carries decoder controls through ID/EX, EX/MEM and MEM/WB. Inserts
//            bubbles on a branch flush or a load-use stall, and freezes on hold.
// Macro    : HAZARD_DETECT_EN enables load-use detection (stall_out).
// Revision : 1.0 - initial release
// ============================================================================
module control_pipe #(
   parameter int REG_W    = 5,
   parameter int ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [1:0]       id_aluOp,
   input  logic             id_aluSrc,
   input  logic             id_branch,
   input  logic             id_isZeroBranch,
   input  logic             id_isUnconBranch,
   input  logic             id_memRead,
   input  logic             id_memWrite,
   input  logic             id_regWrite,
   input  logic             id_mem2reg,
   input  logic [REG_W-1:0] id_rd,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             hold,
   input  logic             flush,
   output logic             stall_out,
   output logic             ex_valid,
   output logic [1:0]       ex_aluOp,
   output logic             ex_aluSrc,
   output logic             mem_valid,
   output logic             mem_branch,
   output logic             mem_isZeroBranch,
   output logic             mem_isUnconBranch,
   output logic             mem_memRead,
   output logic             mem_memWrite,
   output logic             wb_valid,
   output logic             wb_regWrite,
   output logic             wb_mem2reg,
   output logic [REG_W-1:0] ex_rd,
   output logic [REG_W-1:0] mem_rd,
   output logic [REG_W-1:0] wb_rd
);

   localparam logic [REG_W-1:0] c_zeroReg = REG_W'(ZERO_REG);

   typedef struct packed {
      logic             valid;
      logic [1:0]       aluOp;
      logic             aluSrc;
      logic             branch;
      logic             isZeroBranch;
      logic             isUnconBranch;
      logic             memRead;
      logic             memWrite;
      logic             regWrite;
      logic             mem2reg;
      logic [REG_W-1:0] rd;
   } idExCtrl_t;

   typedef struct packed {
      logic             valid;
      logic             branch;
      logic             isZeroBranch;
      logic             isUnconBranch;
      logic             memRead;
      logic             memWrite;
      logic             regWrite;
      logic             mem2reg;
      logic [REG_W-1:0] rd;
   } exMemCtrl_t;

   typedef struct packed {
      logic             valid;
      logic             regWrite;
      logic             mem2reg;
      logic [REG_W-1:0] rd;
   } memWbCtrl_t;

   idExCtrl_t  r_idEx;
   exMemCtrl_t r_exMem;
   memWbCtrl_t r_memWb;
   idExCtrl_t  w_idCtrl;
   exMemCtrl_t w_exMemNext;
   memWbCtrl_t w_memWbNext;
   logic       w_loadUse;

   // An invalid ID slot, or a don't-care mem2reg, must enter the pipe as clean zeros.
   always_comb begin
      w_idCtrl = '0;
      if (id_valid) begin
         w_idCtrl.valid         = 1'b1;
         w_idCtrl.aluOp         = id_aluOp;
         w_idCtrl.aluSrc        = id_aluSrc;
         w_idCtrl.branch        = id_branch;
         w_idCtrl.isZeroBranch  = id_isZeroBranch;
         w_idCtrl.isUnconBranch = id_isUnconBranch;
         w_idCtrl.memRead       = id_memRead;
         w_idCtrl.memWrite      = id_memWrite;
         w_idCtrl.regWrite      = id_regWrite;
         w_idCtrl.mem2reg       = id_regWrite & id_mem2reg;
         w_idCtrl.rd            = id_rd;
      end
   end

   always_comb begin
      w_exMemNext.valid         = r_idEx.valid;
      w_exMemNext.branch        = r_idEx.branch;
      w_exMemNext.isZeroBranch  = r_idEx.isZeroBranch;
      w_exMemNext.isUnconBranch = r_idEx.isUnconBranch;
      w_exMemNext.memRead       = r_idEx.memRead;
      w_exMemNext.memWrite      = r_idEx.memWrite;
      w_exMemNext.regWrite      = r_idEx.regWrite;
      w_exMemNext.mem2reg       = r_idEx.mem2reg;
      w_exMemNext.rd            = r_idEx.rd;
      w_memWbNext.valid         = r_exMem.valid;
      w_memWbNext.regWrite      = r_exMem.regWrite;
      w_memWbNext.mem2reg       = r_exMem.mem2reg;
      w_memWbNext.rd            = r_exMem.rd;
   end

`ifdef HAZARD_DETECT_EN
   assign w_loadUse = id_valid & r_idEx.valid & r_idEx.memRead & (r_idEx.rd != c_zeroReg) &
                      ((id_rs1_used & (id_rs1 == r_idEx.rd)) |
                       (id_rs2_used & (id_rs2 == r_idEx.rd)));
`else
   logic w_unusedHazardIns;
   assign w_unusedHazardIns = ^{id_rs1, id_rs2, id_rs1_used, id_rs2_used, c_zeroReg};
   assign w_loadUse         = 1'b0;
`endif

   // A flushed ID instruction is dead, so it never needs to stall.
   assign stall_out = w_loadUse & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idEx  <= '0;
         r_exMem <= '0;
         r_memWb <= '0;
      end else if (flush) begin
         r_idEx  <= '0;
         r_exMem <= '0;
         r_memWb <= w_memWbNext;
      end else if (!hold) begin
         r_idEx  <= w_loadUse ? '0 : w_idCtrl;
         r_exMem <= w_exMemNext;
         r_memWb <= w_memWbNext;
      end
   end

   assign ex_valid          = r_idEx.valid;
   assign ex_aluOp          = r_idEx.aluOp;
   assign ex_aluSrc         = r_idEx.aluSrc;
   assign ex_rd             = r_idEx.rd;
   assign mem_valid         = r_exMem.valid;
   assign mem_branch        = r_exMem.branch;
   assign mem_isZeroBranch  = r_exMem.isZeroBranch;
   assign mem_isUnconBranch = r_exMem.isUnconBranch;
   assign mem_memRead       = r_exMem.memRead;
   assign mem_memWrite      = r_exMem.memWrite;
   assign mem_rd            = r_exMem.rd;
   assign wb_valid          = r_memWb.valid;
   assign wb_regWrite       = r_memWb.regWrite;
   assign wb_mem2reg        = r_memWb.mem2reg;
   assign wb_rd             = r_memWb.rd;

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_pipe
// Purpose  : Directed self-checking bench for control_pipe; WB results are
//            scoreboarded in issue order. Honours HAZARD_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_pipe;

`ifdef HAZARD_DETECT_EN
   localparam logic c_hz = 1'b1;
`else
   localparam logic c_hz = 1'b0;
`endif

   typedef struct packed {
      logic       valid;
      logic [1:0] aluOp;
      logic       aluSrc, branch, zb, ub, mr, mw, rw, m2r;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2;
   } inst_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic id_valid, id_aluSrc, id_branch, id_isZeroBranch, id_isUnconBranch;
   logic id_memRead, id_memWrite, id_regWrite, id_mem2reg, id_rs1_used, id_rs2_used;
   logic [1:0] id_aluOp;
   logic [4:0] id_rd, id_rs1, id_rs2;
   logic hold = 1'b0, flush = 1'b0;
   logic stall_out, ex_valid, ex_aluSrc, mem_valid, mem_branch, mem_isZeroBranch;
   logic mem_isUnconBranch, mem_memRead, mem_memWrite, wb_valid, wb_regWrite, wb_mem2reg;
   logic [1:0] ex_aluOp;
   logic [4:0] ex_rd, mem_rd, wb_rd;
   logic [28:0] allOuts;

   int nAssert = 0, nFail = 0;
   logic [6:0] sb[$];
   logic [6:0] expWb;

   always #5 clk = ~clk;

   control_pipe #(.REG_W(5), .ZERO_REG(31)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_aluOp(id_aluOp),
      .id_aluSrc(id_aluSrc), .id_branch(id_branch), .id_isZeroBranch(id_isZeroBranch),
      .id_isUnconBranch(id_isUnconBranch), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
      .id_regWrite(id_regWrite), .id_mem2reg(id_mem2reg), .id_rd(id_rd), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .hold(hold),
      .flush(flush), .stall_out(stall_out), .ex_valid(ex_valid), .ex_aluOp(ex_aluOp),
      .ex_aluSrc(ex_aluSrc), .mem_valid(mem_valid), .mem_branch(mem_branch),
      .mem_isZeroBranch(mem_isZeroBranch), .mem_isUnconBranch(mem_isUnconBranch),
      .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .wb_valid(wb_valid),
      .wb_regWrite(wb_regWrite), .wb_mem2reg(wb_mem2reg), .ex_rd(ex_rd), .mem_rd(mem_rd),
      .wb_rd(wb_rd)
   );

   assign allOuts = {stall_out, ex_valid, ex_aluOp, ex_aluSrc, mem_valid, mem_branch,
                     mem_isZeroBranch, mem_isUnconBranch, mem_memRead, mem_memWrite,
                     wb_valid, wb_regWrite, wb_mem2reg, ex_rd, mem_rd, wb_rd};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample 1 time unit later, and retire any WB result.
   task automatic tick();
      @(posedge clk);
      #1;
      if (wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_wb", {25'd0, wb_regWrite, wb_mem2reg, wb_rd}, 32'hFFFF_FFFF);
         end else begin
            expWb = sb.pop_front();
            chk("sb_wb", {25'd0, wb_regWrite, wb_mem2reg, wb_rd}, {25'd0, expWb});
         end
      end
   endtask

   task automatic drive(input inst_t i);
      id_valid = i.valid;   id_aluOp = i.aluOp;    id_aluSrc = i.aluSrc;
      id_branch = i.branch; id_isZeroBranch = i.zb; id_isUnconBranch = i.ub;
      id_memRead = i.mr;    id_memWrite = i.mw;    id_regWrite = i.rw;
      id_mem2reg = i.m2r;   id_rd = i.rd;          id_rs1 = i.rs1;
      id_rs2 = i.rs2;       id_rs1_used = i.u1;    id_rs2_used = i.u2;
      #1;
   endtask

   // Issue an instruction and record what WB must eventually show for it.
   task automatic issue(input inst_t i);
      drive(i);
      sb.push_back({i.rw, i.rw & i.m2r, i.rd});
   endtask

   function automatic inst_t nop();
      inst_t i = '0;
      return i;
   endfunction

   function automatic inst_t mkAdd(input logic [4:0] rd, rs1, rs2, input logic u2);
      inst_t i = '0;
      i.valid = 1'b1; i.aluOp = 2'b10; i.rw = 1'b1;
      i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = u2;
      return i;
   endfunction

   function automatic inst_t mkLdur(input logic [4:0] rd, rs1);
      inst_t i = '0;
      i.valid = 1'b1; i.aluSrc = 1'b1; i.mr = 1'b1; i.rw = 1'b1; i.m2r = 1'b1;
      i.rd = rd; i.rs1 = rs1; i.u1 = 1'b1;
      return i;
   endfunction

   function automatic inst_t mkStur(input logic [4:0] rs1, rs2);
      inst_t i = '0;
      i.valid = 1'b1; i.aluSrc = 1'b1; i.mw = 1'b1; i.m2r = 1'bx;
      i.rd = rs2; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1;
      return i;
   endfunction

   function automatic inst_t mkCbz(input logic [4:0] rd, rs2);
      inst_t i = '0;
      i.valid = 1'b1; i.aluOp = 2'b01; i.branch = 1'b1; i.zb = 1'b1; i.m2r = 1'bx;
      i.rd = rd; i.rs2 = rs2; i.u2 = 1'b1;
      return i;
   endfunction

   initial begin
      inst_t t;
      drive(nop());
      tick();
      tick();
      chk("reset_outs", {3'd0, allOuts}, 32'd0);
      rst_n = 1'b1;

      // Plain ADD walks one stage per cycle
      issue(mkAdd(5'd3, 5'd1, 5'd2, 1'b1));
      tick();
      drive(nop());
      chk("add_ex_valid", ex_valid, 1);
      chk("add_ex_aluOp", ex_aluOp, 2'b10);
      chk("add_ex_aluSrc", ex_aluSrc, 0);
      chk("add_ex_rd", ex_rd, 3);
      tick();
      chk("add_mem_valid", mem_valid, 1);
      chk("add_mem_ctrl", {mem_branch, mem_isZeroBranch, mem_isUnconBranch, mem_memRead, mem_memWrite}, 0);
      chk("add_mem_rd", mem_rd, 3);
      chk("nop_ex_bubble", {ex_valid, ex_aluOp, ex_aluSrc, ex_rd}, 0);
      tick();
      chk("add_wb_regWrite", wb_regWrite, 1);
      chk("add_wb_rd", wb_rd, 3);
      tick();
      chk("drain_wb_valid", wb_valid, 0);

      // Load-use: LDUR x5 then ADD reading x5
      issue(mkLdur(5'd5, 5'd1));
      tick();
      issue(mkAdd(5'd6, 5'd5, 5'd2, 1'b1));
      chk("lu_stall", stall_out, c_hz);
      tick();
`ifdef HAZARD_DETECT_EN
      chk("lu_bubble_ex", ex_valid, 0);
      chk("lu_mem_load", mem_memRead, 1);
      chk("lu_stall_clears", stall_out, 0);
      tick();
`endif
      drive(nop());
      chk("lu_add_ex_valid", ex_valid, 1);
      chk("lu_add_ex_rd", ex_rd, 6);
      tick(); tick(); tick();

      // XZR never hazards; an unused rs2 never hazards
      issue(mkLdur(5'd31, 5'd1));
      tick();
      t = mkAdd(5'd8, 5'd31, 5'd2, 1'b1);
      issue(t);
      chk("xzr_no_stall", stall_out, 0);
      tick();
      issue(mkLdur(5'd9, 5'd1));
      tick();
      drive(mkAdd(5'd10, 5'd1, 5'd9, 1'b1));
      chk("rs2_used_stall", stall_out, c_hz);
      issue(mkAdd(5'd10, 5'd1, 5'd9, 1'b0));
      chk("rs2_unused_no_stall", stall_out, 0);
      tick();
      drive(nop());
      tick(); tick(); tick();

      // CBZ in MEM with flush and hold together; load-use masked by flush
      issue(mkCbz(5'd12, 5'd4));
      tick();
      drive(mkLdur(5'd5, 5'd2));
      tick();
      chk("cbz_mem_branch", {mem_branch, mem_isZeroBranch, mem_isUnconBranch}, 3'b110);
      drive(mkAdd(5'd6, 5'd5, 5'd2, 1'b0));
      flush = 1'b1; hold = 1'b1;
      #1;
      chk("flush_masks_stall", stall_out, 0);
      tick();
      chk("flush_ex_valid", ex_valid, 0);
      chk("flush_mem_bubble", {mem_valid, mem_memRead, mem_rd}, 0);
      chk("flush_wb_cbz", {wb_valid, wb_regWrite, wb_mem2reg}, 3'b100);
      hold = 1'b0;
      drive(nop());
      tick();
      chk("flush2_all_bubble", {3'd0, allOuts}, 32'd0);
      flush = 1'b0;

      // Hold freezes STUR in EX
      issue(mkAdd(5'd13, 5'd1, 5'd2, 1'b1));
      tick();
      issue(mkStur(5'd1, 5'd7));
      tick();
      drive(nop());
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_ex", {ex_valid, ex_aluOp, ex_aluSrc, ex_rd}, {1'b1, 2'b00, 1'b1, 5'd7});
         chk("hold_mem", {mem_valid, mem_memWrite, mem_rd}, {1'b1, 1'b0, 5'd13});
         chk("hold_wb", wb_valid, 0);
      end
      hold = 1'b0;
      tick();
      chk("stur_memWrite_on", mem_memWrite, 1);
      tick();
      chk("stur_memWrite_off", mem_memWrite, 0);
      tick();

      // Asynchronous reset with ADDs in every stage
      issue(mkAdd(5'd14, 5'd1, 5'd2, 1'b1));
      tick();
      drive(mkAdd(5'd15, 5'd1, 5'd2, 1'b1));
      tick();
      drive(mkAdd(5'd16, 5'd1, 5'd2, 1'b1));
      tick();
      chk("full_pipe", {ex_valid, mem_valid, wb_valid, ex_rd}, {3'b111, 5'd16});
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outs", {3'd0, allOuts}, 32'd0);
      drive(nop());
      tick();
      chk("in_reset_outs", {3'd0, allOuts}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_reset_outs", {3'd0, allOuts}, 32'd0);
      tick();
      chk("post_reset_outs2", {3'd0, allOuts}, 32'd0);
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
`default_nettype wire
